axil_regbank_gen: RTL

- Parametrised AXI4-Lite slave register bank; the next generation of the fixed 4-register, 32-bit slave used in the crypto IPs.
- Adds configurable register count and width, per-register read-only mode (values fed by user logic), WSTRB byte lanes, SLVERR on out-of-range addresses, decoupled AW/W acceptance and per-register write pulses.
- Sits between the PS AXI interconnect and the AES/DES/GCD cores.

---
 rtl/axil_regbank_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axil_regbank_gen.sv
// AXI4-Lite register bank: NUM_REGS x DATA_WIDTH, byte strobes, per-register read-only, SLVERR on bad index.
// Write: B one cycle after the later of AW/W handshakes; read: R on the AR edge; AW/W/AR blocked while B/R pending.
module axil_regbank_gen #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           s00_axi_aclk,
    input  logic                           s00_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                     s00_axi_awprot,
    input  logic                           s00_axi_awvalid,
    output logic                           s00_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                           s00_axi_wvalid,
    output logic                           s00_axi_wready,
    output logic [1:0]                     s00_axi_bresp,
    output logic                           s00_axi_bvalid,
    input  logic                           s00_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                     s00_axi_arprot,
    input  logic                           s00_axi_arvalid,
    output logic                           s00_axi_arready,
    output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                     s00_axi_rresp,
    output logic                           s00_axi_rvalid,
    input  logic                           s00_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int SB   = $clog2(NB);
    localparam int IDXW = ADDR_WIDTH - SB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_aw_held;
    logic [IDXW-1:0]       r_aw_idx;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_aw_inrange;
    logic [IDXW-1:0]       w_ar_idx;
    logic                  w_ar_inrange;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    // Readies depend only on registered state and reset, never on a valid input.
    assign s00_axi_awready = !s00_axi_areset && !r_aw_held && !r_bvalid;
    assign s00_axi_wready  = !s00_axi_areset && !r_w_held && !r_bvalid;
    assign s00_axi_arready = !s00_axi_areset && !r_rvalid;

    assign w_aw_hs      = s00_axi_awvalid && s00_axi_awready;
    assign w_w_hs       = s00_axi_wvalid && s00_axi_wready;
    assign w_ar_hs      = s00_axi_arvalid && s00_axi_arready;
    assign w_commit     = r_aw_held && r_w_held;
    assign w_aw_inrange = 32'(r_aw_idx) < NUM_REGS;
    assign w_ar_idx     = s00_axi_araddr[ADDR_WIDTH-1:SB];
    assign w_ar_inrange = 32'(w_ar_idx) < NUM_REGS;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDXW'(i))
                w_rd_data = RO_MASK[i] ? reg_d[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s00_axi_awaddr[ADDR_WIDTH-1:SB];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end

            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_aw_inrange ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_aw_inrange && r_aw_idx == IDXW'(i)) begin
                        r_wr_pulse[i] <= 1'b1;
                        if (!RO_MASK[i]) begin
                            for (int b = 0; b < NB; b++)
                                if (r_wstrb[b])
                                    r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                    end
                end
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            // A same-edge write to this register lands after the read sample.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_ar_inrange ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[g] ? reg_d[g*DATA_WIDTH +: DATA_WIDTH] : r_regs[g];
    end

    assign s00_axi_bvalid = r_bvalid;
    assign s00_axi_bresp  = r_bresp;
    assign s00_axi_rvalid = r_rvalid;
    assign s00_axi_rdata  = r_rdata;
    assign s00_axi_rresp  = r_rresp;
    assign reg_wr_pulse   = r_wr_pulse;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[SB-1:0], s00_axi_araddr[SB-1:0], reg_d};

endmodule
